// File: rtl/cve2_data_responder_if.sv
// Data-bus bundle between the core LSU and a memory responder.
// The master side drives the request; the slave side returns gnt/rvalid.
interface cve2_data_responder_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req,
    output data_we,
    output data_be,
    output data_addr,
    output data_wdata,
    input  data_gnt,
    input  data_rvalid,
    input  data_rdata,
    input  data_err
  );

  modport slave (
    input  data_req,
    input  data_we,
    input  data_be,
    input  data_addr,
    input  data_wdata,
    output data_gnt,
    output data_rvalid,
    output data_rdata,
    output data_err
  );
endinterface

// File: rtl/cve2_data_responder.sv
// Byte-writable word SRAM answering the core data bus with
// programmable grant latency, stall injection and range errors.
module cve2_data_responder #(
  parameter int unsigned MemWords = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned GntDelay = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  cve2_data_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(MemWords);
  localparam logic [2:0]  GD = 3'(GntDelay);
  localparam bit          NoDelay = (GntDelay == 0);
  localparam logic [29:0] BaseWord = BaseAddr[31:2];

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic [31:0] r_mem [MemWords];

  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;

  logic [29:0]   w_word;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_gnt;
  logic          w_acc;
  logic          w_elig;

  // Base is word-aligned, so word-level subtraction equals byte offset >> 2
  assign w_word     = bus.data_addr[31:2] - BaseWord;
  assign w_in_range = {2'b00, w_word} < 32'(MemWords);
  assign w_idx      = w_word[AW-1:0];

  assign w_elig = (r_cnt >= GD);

  always_comb begin
    w_gnt       = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (NoDelay) begin
          w_gnt = bus.data_req & ~stall_i;
        end else if (bus.data_req) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = 3'd1;
        end
      end
      WAIT: begin
        w_gnt = bus.data_req & ~stall_i & w_elig;
        if (!bus.data_req || w_gnt) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 3'd0;
        end else if (!w_elig) begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
    if (rst_i) begin
      w_gnt = 1'b0;
    end
  end

  assign w_acc = bus.data_req & w_gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_acc;
      r_err    <= w_acc & ~w_in_range;
      if (w_acc && !bus.data_we && w_in_range) begin
        r_rdata <= r_mem[w_idx];
      end else begin
        r_rdata <= 32'h0;
      end
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_acc && bus.data_we && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end

  // A response still registered when reset arrives is suppressed
  assign bus.data_gnt    = w_gnt;
  assign bus.data_rvalid = r_rvalid & ~rst_i;
  assign bus.data_err    = r_err & ~rst_i;
  assign bus.data_rdata  = rst_i ? 32'h0 : r_rdata;

endmodule

// File: tb/tb_cve2_data_responder.sv
// Directed bench for cve2_data_responder: three instances cover
// zero/nonzero grant delay and an offset address window.
module tb_cve2_data_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req;
  logic        we;
  logic        stall;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  cve2_data_responder_if b0 ();
  cve2_data_responder_if b3 ();
  cve2_data_responder_if bb ();

  assign b0.data_req   = req;
  assign b0.data_we    = we;
  assign b0.data_be    = be;
  assign b0.data_addr  = addr;
  assign b0.data_wdata = wdata;
  assign b3.data_req   = req;
  assign b3.data_we    = we;
  assign b3.data_be    = be;
  assign b3.data_addr  = addr;
  assign b3.data_wdata = wdata;
  assign bb.data_req   = req;
  assign bb.data_we    = we;
  assign bb.data_be    = be;
  assign bb.data_addr  = addr;
  assign bb.data_wdata = wdata;

  cve2_data_responder #(
    .MemWords(1024), .BaseAddr(32'h0), .GntDelay(0)
  ) u_d0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(b0)
  );

  cve2_data_responder #(
    .MemWords(1024), .BaseAddr(32'h0), .GntDelay(3)
  ) u_d3 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(b3)
  );

  cve2_data_responder #(
    .MemWords(1024), .BaseAddr(32'h1000), .GntDelay(0)
  ) u_db (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bus(bb)
  );

  typedef struct {
    int          dut;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rq, input logic w,
                      input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] wd, input logic st);
    @(posedge clk);
    #1;
    rst   = r;
    req   = rq;
    we    = w;
    be    = b;
    addr  = a;
    wdata = wd;
    stall = st;
    @(negedge clk);
  endtask

  task automatic get(input int d, output logic g, output logic v,
                     output logic e, output logic [31:0] rd);
    case (d)
      1:       begin g = b3.data_gnt; v = b3.data_rvalid;
                     e = b3.data_err; rd = b3.data_rdata; end
      2:       begin g = bb.data_gnt; v = bb.data_rvalid;
                     e = bb.data_err; rd = bb.data_rdata; end
      default: begin g = b0.data_gnt; v = b0.data_rvalid;
                     e = b0.data_err; rd = b0.data_rdata; end
    endcase
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
  endtask

  logic        g, v, e;
  logic [31:0] rd;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; stall = 1'b0;
    be = 4'h0; addr = 32'h0; wdata = 32'h0;

    // dut, req, we, be, addr, wdata, stall | gnt, rvalid, err, rdata
    tbl.push_back('{0,1,1,4'hF,32'h0000,32'h01234567,0, 1,0,0,32'h0});
    tbl.push_back('{0,1,1,4'hF,32'h0010,32'hDEADBEEF,0, 1,1,0,32'h0});
    tbl.push_back('{0,1,0,4'hF,32'h0010,32'h0,0,        1,1,0,32'h0});
    tbl.push_back('{0,1,1,4'h5,32'h0010,32'h11223344,0, 1,1,0,32'hDEADBEEF});
    tbl.push_back('{0,1,0,4'hF,32'h0013,32'h0,0,        1,1,0,32'h0});
    tbl.push_back('{0,1,1,4'h0,32'h0010,32'hFFFFFFFF,0, 1,1,0,32'hDE22BE44});
    tbl.push_back('{0,1,0,4'hF,32'h0010,32'h0,0,        1,1,0,32'h0});
    tbl.push_back('{0,1,1,4'hF,32'h1000,32'hCAFEF00D,0, 1,1,0,32'hDE22BE44});
    tbl.push_back('{0,1,0,4'hF,32'h0000,32'h0,0,        1,1,1,32'h0});
    tbl.push_back('{0,1,0,4'hF,32'h0000,32'h0,1,        0,1,0,32'h01234567});
    tbl.push_back('{0,1,0,4'hF,32'h0000,32'h0,1,        0,0,0,32'h0});
    tbl.push_back('{0,1,0,4'hF,32'h1004,32'h0,0,        1,0,0,32'h0});
    tbl.push_back('{0,0,0,4'h0,32'h0000,32'h0,0,        0,1,1,32'h0});
    tbl.push_back('{0,0,0,4'h0,32'h0000,32'h0,0,        0,0,0,32'h0});
    tbl.push_back('{2,1,1,4'hF,32'h1000,32'h00000000,0, 1,0,0,32'h0});
    tbl.push_back('{2,1,1,4'hF,32'h1FFC,32'h55AA55AA,0, 1,1,0,32'h0});
    tbl.push_back('{2,1,1,4'hF,32'h2000,32'h12345678,0, 1,1,0,32'h0});
    tbl.push_back('{2,1,0,4'hF,32'h1000,32'h0,0,        1,1,1,32'h0});
    tbl.push_back('{2,1,0,4'hF,32'h1FFC,32'h0,0,        1,1,0,32'h0});
    tbl.push_back('{2,1,0,4'hF,32'h0FFC,32'h0,0,        1,1,0,32'h55AA55AA});
    tbl.push_back('{2,0,0,4'h0,32'h0000,32'h0,0,        0,1,1,32'h0});
    tbl.push_back('{2,0,0,4'h0,32'h0000,32'h0,0,        0,0,0,32'h0});

    // Reset: outputs quiet and gnt held low even with req asserted
    step(1, 1, 0, 4'hF, 32'h10, 32'h0, 0);
    for (int d = 0; d < 3; d++) begin
      get(d, g, v, e, rd);
      chk($sformatf("rst_gnt%0d", d), 32'(g), 32'h0);
      chk($sformatf("rst_rv%0d", d), 32'(v), 32'h0);
      chk($sformatf("rst_err%0d", d), 32'(e), 32'h0);
      chk($sformatf("rst_rd%0d", d), rd, 32'h0);
    end
    idle(1);
    get(0, g, v, e, rd);
    chk("post_rst_rv", 32'(v), 32'h0);

    foreach (tbl[i]) begin
      step(0, tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr,
           tbl[i].wdata, tbl[i].stall);
      get(tbl[i].dut, g, v, e, rd);
      chk($sformatf("v%0d_gnt", i), 32'(g), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_rv", i), 32'(v), 32'(tbl[i].rvalid));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(tbl[i].err));
      chk($sformatf("v%0d_rd", i), rd, tbl[i].rdata);
    end

    // Stall for five cycles, then grant on release
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 4'hF, 32'h10, 32'h0, 1);
      chk($sformatf("stall%0d_gnt", k), 32'(b0.data_gnt), 32'h0);
      chk($sformatf("stall%0d_rv", k), 32'(b0.data_rvalid), 32'h0);
    end
    step(0, 1, 0, 4'hF, 32'h10, 32'h0, 0);
    chk("unstall_gnt", 32'(b0.data_gnt), 32'h1);
    idle(1);
    chk("unstall_rv", 32'(b0.data_rvalid), 32'h1);
    chk("unstall_rd", b0.data_rdata, 32'hDE22BE44);

    // GntDelay=3: grant on the fourth cycle of a held request
    idle(1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 4'hF, 32'h10, 32'h0, 0);
      chk($sformatf("gd3_gnt%0d", k), 32'(b3.data_gnt),
          (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("gd3_rv%0d", k), 32'(b3.data_rvalid), 32'h0);
    end
    idle(1);
    chk("gd3_rv", 32'(b3.data_rvalid), 32'h1);
    chk("gd3_err", 32'(b3.data_err), 32'h0);
    idle(1);
    chk("gd3_rv_end", 32'(b3.data_rvalid), 32'h0);

    // Dropped request must restart the delay count from scratch
    step(0, 1, 0, 4'hF, 32'h10, 32'h0, 0);
    chk("drop_gnt0", 32'(b3.data_gnt), 32'h0);
    idle(1);
    chk("drop_gnt1", 32'(b3.data_gnt), 32'h0);
    chk("drop_rv1", 32'(b3.data_rvalid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 4'hF, 32'h10, 32'h0, 0);
      chk($sformatf("regnt%0d", k), 32'(b3.data_gnt),
          (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("regnt_rv%0d", k), 32'(b3.data_rvalid), 32'h0);
    end
    idle(1);
    chk("regnt_rv", 32'(b3.data_rvalid), 32'h1);

    // Reset right after a read grant drops the response
    step(0, 1, 1, 4'hF, 32'h20, 32'h0BADF00D, 0);
    chk("rw_gnt", 32'(b0.data_gnt), 32'h1);
    step(0, 1, 0, 4'hF, 32'h20, 32'h0, 0);
    chk("rr_gnt", 32'(b0.data_gnt), 32'h1);
    step(1, 1, 0, 4'hF, 32'h20, 32'h0, 0);
    chk("mid_rst_gnt", 32'(b0.data_gnt), 32'h0);
    chk("mid_rst_rv", 32'(b0.data_rvalid), 32'h0);
    chk("mid_rst_err", 32'(b0.data_err), 32'h0);
    chk("mid_rst_rd", b0.data_rdata, 32'h0);
    idle(1);
    chk("after_rst_rv", 32'(b0.data_rvalid), 32'h0);
    chk("after_rst_err", 32'(b0.data_err), 32'h0);
    chk("after_rst_rd", b0.data_rdata, 32'h0);
    step(0, 1, 0, 4'hF, 32'h20, 32'h0, 0);
    chk("keep_gnt", 32'(b0.data_gnt), 32'h1);
    idle(1);
    chk("keep_rv", 32'(b0.data_rvalid), 32'h1);
    chk("keep_rd", b0.data_rdata, 32'h0BADF00D);
    chk("keep_err", 32'(b0.data_err), 32'h0);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
